// File: rtl/alu_pkg.sv
// Shared types for the ALU and its command sequencer: opcodes, flag indices,
// sequencer FSM states and the illegal-opcode check.
package alu_pkg;

  typedef enum logic [3:0] {
    OP_ADD    = 4'd0,
    OP_SUB    = 4'd1,
    OP_AND    = 4'd2,
    OP_OR     = 4'd3,
    OP_XOR    = 4'd4,
    OP_INC    = 4'd5,
    OP_PASS_A = 4'd6,
    OP_PASS_B = 4'd7
  } opcode_e;

  localparam int OVF  = 2;
  localparam int NEG  = 1;
  localparam int ZERO = 0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_e;

  // The upper half of the opcode space is reserved.
  function automatic logic is_illegal(input logic [3:0] op);
    return op[3];
  endfunction

endpackage

// File: rtl/alu_sequencer_if.sv
// Command/response handshake bundle between the issue logic (master) and
// the ALU sequencer (slave).
interface alu_sequencer_if #(parameter int BW = 16);
  logic          cmd_valid;
  logic          cmd_ready;
  logic [3:0]    cmd_opcode;
  logic [BW-1:0] cmd_a;
  logic [BW-1:0] cmd_b;
  logic          cmd_use_acc;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [BW-1:0] rsp_data;
  logic [2:0]    rsp_flags;
  logic          rsp_err;
  logic [15:0]   op_count;

  modport master (
    output cmd_valid, cmd_opcode, cmd_a, cmd_b, cmd_use_acc, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_data, rsp_flags, rsp_err, op_count
  );

  modport slave (
    input  cmd_valid, cmd_opcode, cmd_a, cmd_b, cmd_use_acc, rsp_ready,
    output cmd_ready, rsp_valid, rsp_data, rsp_flags, rsp_err, op_count
  );
endinterface

// File: rtl/alu_sequencer_alu.sv
// Combinational BW-bit ALU; flags are {overflow, negative, zero} and are all
// cleared for reserved opcodes.
module alu
  import alu_pkg::*;
#(
  parameter int BW = 16
) (
  input  logic [BW-1:0] in_a,
  input  logic [BW-1:0] in_b,
  input  logic [3:0]    opcode,
  output logic [BW-1:0] out,
  output logic [2:0]    flags
);

  logic ovf;

  always_comb begin
    out = '0;
    ovf = 1'b0;
    case (opcode)
      OP_ADD: begin
        out = in_a + in_b;
        ovf = (in_a[BW-1] == in_b[BW-1]) && (out[BW-1] != in_a[BW-1]);
      end
      OP_SUB: begin
        out = in_a - in_b;
        ovf = (in_a[BW-1] != in_b[BW-1]) && (out[BW-1] != in_a[BW-1]);
      end
      OP_AND:    out = in_a & in_b;
      OP_OR:     out = in_a | in_b;
      OP_XOR:    out = in_a ^ in_b;
      OP_INC: begin
        out = in_a + BW'(1);
        ovf = !in_a[BW-1] && out[BW-1];
      end
      OP_PASS_A: out = in_a;
      OP_PASS_B: out = in_b;
      default:   out = '0;
    endcase
  end

  always_comb begin
    flags = 3'b000;
    if (!is_illegal(opcode)) begin
      flags[OVF]  = ovf;
      flags[NEG]  = out[BW-1];
      flags[ZERO] = (out == '0);
    end
  end

endmodule

// File: rtl/alu_sequencer.sv
// One-command-at-a-time front end for the ALU: IDLE -> EXEC -> RESP.
// Optional accumulator operand source enabled by `define ALU_SEQ_ACC_EN.
module alu_sequencer
  import alu_pkg::*;
#(
  parameter int BW = 16
) (
  input logic            clk,
  input logic            rst_n,
  alu_sequencer_if.slave bus
);

  state_e        state, state_nxt;
  logic [3:0]    op_q;
  logic [BW-1:0] a_q, b_q;
  logic          ill_q;
  logic [BW-1:0] rsp_data_q;
  logic [2:0]    rsp_flags_q;
  logic          rsp_err_q;
  logic [15:0]   cnt_q;
  logic [BW-1:0] alu_out;
  logic [2:0]    alu_flags;
  logic [BW-1:0] opa;

  alu #(.BW(BW)) u_alu (
    .in_a   (a_q),
    .in_b   (b_q),
    .opcode (op_q),
    .out    (alu_out),
    .flags  (alu_flags)
  );

`ifdef ALU_SEQ_ACC_EN
  logic [BW-1:0] acc_q;

  assign opa = bus.cmd_use_acc ? acc_q : bus.cmd_a;

  // Error responses already carry rsp_data = 0, so the accumulator clears.
  always_ff @(posedge clk) begin
    if (!rst_n)
      acc_q <= '0;
    else if (state == RESP && bus.rsp_ready)
      acc_q <= rsp_data_q;
  end
`else
  logic unused_use_acc;

  assign opa            = bus.cmd_a;
  assign unused_use_acc = bus.cmd_use_acc;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.cmd_valid) state_nxt = EXEC;
      EXEC:    state_nxt = RESP;
      RESP:    if (bus.rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      op_q        <= '0;
      a_q         <= '0;
      b_q         <= '0;
      ill_q       <= 1'b0;
      rsp_data_q  <= '0;
      rsp_flags_q <= '0;
      rsp_err_q   <= 1'b0;
      cnt_q       <= '0;
    end else begin
      case (state)
        IDLE: if (bus.cmd_valid) begin
          op_q  <= bus.cmd_opcode;
          a_q   <= opa;
          b_q   <= bus.cmd_b;
          ill_q <= is_illegal(bus.cmd_opcode);
        end
        EXEC: begin
          rsp_data_q  <= ill_q ? '0 : alu_out;
          rsp_flags_q <= ill_q ? 3'b000 : alu_flags;
          rsp_err_q   <= ill_q;
        end
        RESP: if (bus.rsp_ready) cnt_q <= cnt_q + 16'd1;
        default: ;
      endcase
    end
  end

  assign bus.cmd_ready = (state == IDLE);
  assign bus.rsp_valid = (state == RESP);
  assign bus.rsp_data  = rsp_data_q;
  assign bus.rsp_flags = rsp_flags_q;
  assign bus.rsp_err   = rsp_err_q;
  assign bus.op_count  = cnt_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed scoreboard bench for alu_sequencer: the driver queues expected
// responses, a negedge monitor compares every cycle rsp_valid is high.
module tb_alu_sequencer;
  localparam int BW = 16;

  typedef struct {
    logic [BW-1:0] data;
    logic [2:0]    flags;
    logic          err;
    logic [15:0]   cnt;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  alu_sequencer_if #(.BW(BW)) ifc ();

  alu_sequencer #(.BW(BW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifc.slave)
  );

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  logic [15:0] exp_cnt = 16'd0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every valid cycle must match the queue head (also covers hold stability).
  always @(negedge clk) begin
    if (rst_n && ifc.rsp_valid) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_rsp: got data %0h with empty scoreboard", ifc.rsp_data);
      end else begin
        chk("rsp_data",  32'(ifc.rsp_data),  32'(q[0].data));
        chk("rsp_flags", 32'(ifc.rsp_flags), 32'(q[0].flags));
        chk("rsp_err",   32'(ifc.rsp_err),   32'(q[0].err));
        chk("op_count",  32'(ifc.op_count),  32'(q[0].cnt));
        if (ifc.rsp_ready) void'(q.pop_front());
      end
    end
  end

  task automatic push_exp(input logic [BW-1:0] d, input logic [2:0] f, input logic e);
    exp_t x;
    x.data = d; x.flags = f; x.err = e; x.cnt = exp_cnt;
    q.push_back(x);
    exp_cnt++;
  endtask

  task automatic drive_cmd(input logic [3:0] op, input logic [BW-1:0] a,
                           input logic [BW-1:0] b, input logic ua);
    ifc.cmd_valid   = 1'b1;
    ifc.cmd_opcode  = op;
    ifc.cmd_a       = a;
    ifc.cmd_b       = b;
    ifc.cmd_use_acc = ua;
  endtask

  // Called at posedge+1; returns at posedge+1 after the response handshake.
  task automatic send(input logic [3:0] op, input logic [BW-1:0] a, input logic [BW-1:0] b,
                      input logic ua, input logic [BW-1:0] ed, input logic [2:0] ef,
                      input logic ee);
    int n = 0;
    while (!ifc.cmd_ready && n < 50) begin @(posedge clk); #1; n++; end
    chk("cmd_ready_wait", 32'(ifc.cmd_ready), 32'd1);
    drive_cmd(op, a, b, ua);
    push_exp(ed, ef, ee);
    @(posedge clk); #1;
    ifc.cmd_valid = 1'b0;
    chk("lat_exec_no_valid", 32'(ifc.rsp_valid), 32'd0);
    @(posedge clk); #1;
    chk("lat_resp_valid", 32'(ifc.rsp_valid), 32'd1);
    n = 0;
    while (!(ifc.rsp_valid && ifc.rsp_ready) && n < 50) begin @(posedge clk); #1; n++; end
    @(posedge clk); #1;
  endtask

  initial begin
    logic [BW-1:0] acc_exp;
    ifc.cmd_valid = 1'b0; ifc.cmd_opcode = '0; ifc.cmd_a = '0; ifc.cmd_b = '0;
    ifc.cmd_use_acc = 1'b0; ifc.rsp_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    chk("rst_cmd_ready", 32'(ifc.cmd_ready), 32'd1);
    chk("rst_rsp_valid", 32'(ifc.rsp_valid), 32'd0);
    chk("rst_rsp_data",  32'(ifc.rsp_data),  32'd0);
    chk("rst_rsp_flags", 32'(ifc.rsp_flags), 32'd0);
    chk("rst_rsp_err",   32'(ifc.rsp_err),   32'd0);
    chk("rst_op_count",  32'(ifc.op_count),  32'd0);

    send(4'h0, 16'h0002, 16'h0002, 1'b0, 16'h0004, 3'b000, 1'b0);
    chk("op_count_after_add", 32'(ifc.op_count), 32'd1);
    send(4'h1, 16'h7FFF, 16'hFFFF, 1'b0, 16'h8000, 3'b110, 1'b0);
    send(4'h1, 16'h000F, 16'h000F, 1'b0, 16'h0000, 3'b001, 1'b0);
    send(4'hF, 16'h1234, 16'h5678, 1'b0, 16'h0000, 3'b000, 1'b1);
    send(4'h2, 16'h00FF, 16'h0F0F, 1'b0, 16'h000F, 3'b000, 1'b0);
    send(4'h4, 16'hFFFF, 16'hFFFF, 1'b0, 16'h0000, 3'b001, 1'b0);
    send(4'h5, 16'h7FFF, 16'h0000, 1'b0, 16'h8000, 3'b110, 1'b0);
    send(4'h6, 16'h8001, 16'h1111, 1'b0, 16'h8001, 3'b010, 1'b0);
    send(4'h7, 16'hAAAA, 16'h1234, 1'b0, 16'h1234, 3'b000, 1'b0);
    send(4'h0, 16'h8000, 16'h8000, 1'b0, 16'h0000, 3'b101, 1'b0);
    send(4'h8, 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 3'b000, 1'b1);

    // Backpressure: response held, second command waits for the handshake.
    ifc.rsp_ready = 1'b0;
    drive_cmd(4'h3, 16'h000F, 16'hF000, 1'b0);
    push_exp(16'hF00F, 3'b010, 1'b0);
    @(posedge clk); #1;
    drive_cmd(4'h0, 16'h0002, 16'h0002, 1'b0);
    @(posedge clk); #1;
    for (int i = 0; i < 4; i++) begin
      chk("bp_rsp_valid", 32'(ifc.rsp_valid), 32'd1);
      chk("bp_cmd_ready", 32'(ifc.cmd_ready), 32'd0);
      @(posedge clk); #1;
    end
    ifc.rsp_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_cmd_ready_after_hs", 32'(ifc.cmd_ready), 32'd1);
    push_exp(16'h0004, 3'b000, 1'b0);
    @(posedge clk); #1;
    ifc.cmd_valid = 1'b0;
    chk("bp_second_accepted", 32'(ifc.cmd_ready), 32'd0);
    repeat (3) @(posedge clk); #1;

`ifdef ALU_SEQ_ACC_EN
    acc_exp = 16'h0007;
`else
    acc_exp = 16'h0002;
`endif
    send(4'h0, 16'hFFFF, 16'h0003, 1'b1, acc_exp, 3'b000, 1'b0);
    chk("op_count_total", 32'(ifc.op_count), 32'(exp_cnt));

    // Reset during EXEC drops the command.
    drive_cmd(4'h0, 16'h1111, 16'h2222, 1'b0);
    @(posedge clk); #1;
    ifc.cmd_valid = 1'b0;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    exp_cnt = 16'd0;
    chk("mid_rst_rsp_valid", 32'(ifc.rsp_valid), 32'd0);
    chk("mid_rst_cmd_ready", 32'(ifc.cmd_ready), 32'd1);
    chk("mid_rst_op_count",  32'(ifc.op_count),  32'd0);
    repeat (3) @(posedge clk); #1;
    chk("mid_rst_no_rsp", 32'(ifc.rsp_valid), 32'd0);
    send(4'h7, 16'h0000, 16'h0005, 1'b0, 16'h0005, 3'b000, 1'b0);
    chk("op_count_post_rst", 32'(ifc.op_count), 32'd1);

    repeat (2) @(posedge clk); #1;
    chk("scoreboard_empty", 32'(q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
